// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
package loader_pkg;

    // Framing FSM states of the loader
    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERR
    } loader_state_t;

    // First byte of every program image
    localparam logic [7:0] HDR_BYTE = 8'hA5;

    // Start bit + 8 data bits + stop bit
    localparam int BITS_PER_FRAME = 10;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: synchroniser, start-bit qualification, mid-bit sampling.
module uart_rx_core
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ferr
);

    localparam int CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int DATA_BITS = BITS_PER_FRAME - 2;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t        rxState;
    logic             rxMeta;
    logic             rxSync;
    logic             rxPrev;
    logic [CNT_W-1:0] baudCnt;
    logic [2:0]       bitCnt;
    logic [7:0]       shiftReg;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            rxMeta <= 1'b1;
            rxSync <= 1'b1;
            rxPrev <= 1'b1;
        end else begin
            rxMeta <= rx;
            rxSync <= rxMeta;
            rxPrev <= rxSync;
        end
    end

    // Bit-timing state machine; the start bit is re-checked half a bit in
    // so a short low pulse is dropped, and every later sample lands mid-bit
    always_ff @(posedge clk) begin
        if (rst) begin
            rxState  <= RX_IDLE;
            baudCnt  <= '0;
            bitCnt   <= '0;
            shiftReg <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            case (rxState)
                RX_IDLE: begin
                    if (rxPrev && !rxSync) begin
                        rxState <= RX_START;
                        baudCnt <= '0;
                    end
                end
                RX_START: begin
                    if (baudCnt == HALF_LAST) begin
                        baudCnt <= '0;
                        bitCnt  <= '0;
                        rxState <= rxSync ? RX_IDLE : RX_DATA;
                    end else begin
                        baudCnt <= baudCnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (baudCnt == FULL_LAST) begin
                        baudCnt  <= '0;
                        shiftReg <= {rxSync, shiftReg[7:1]};
                        if (bitCnt == LAST_BIT) begin
                            rxState <= RX_STOP;
                        end else begin
                            bitCnt <= bitCnt + 1'b1;
                        end
                    end else begin
                        baudCnt <= baudCnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (baudCnt == FULL_LAST) begin
                        baudCnt <= '0;
                        rxState <= RX_IDLE;
                        if (rxSync) begin
                            rx_valid <= 1'b1;
                            rx_data  <= shiftReg;
                        end else begin
                            rx_ferr <= 1'b1;
                        end
                    end else begin
                        baudCnt <= baudCnt + 1'b1;
                    end
                end
                default: rxState <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_prog_loader.sv
// Boot loader: receives a framed program image over UART, writes it into
// instruction memory and releases the CPU reset once the checksum matches.
module uart_prog_loader
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int IMEM_DEPTH   = 64,
    parameter int ADDR_W       = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              load_err
);

    logic [7:0]    rxData;
    logic          rxValid;
    logic          rxFerr;
    loader_state_t state;
    logic [7:0]    lenLo;
    logic [15:0]   rxLen;
    logic [15:0]   wordCount;
    logic [15:0]   wordIdx;
    logic [1:0]    byteIdx;
    logic [7:0]    sum;
    logic [23:0]   laneBuf;
    logic          inFrame;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) rxCore (
        .clk     (clk),
        .rst     (rst),
        .rx      (uart_rx),
        .rx_data (rxData),
        .rx_valid(rxValid),
        .rx_ferr (rxFerr)
    );

    assign rxLen   = {rxData, lenLo};
    assign inFrame = (state == LEN_LO) || (state == LEN_HI) ||
                     (state == DATA)   || (state == CSUM);

    // Lower three bytes of the word being assembled; the top byte goes
    // straight from rxData into the write so the word leaves one cycle later
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
        // Capture byte lane gi while in DATA
        always_ff @(posedge clk) begin
            if (rst) begin
                laneBuf[gi*8 +: 8] <= '0;
            end else if (rxValid && state == DATA && byteIdx == 2'(gi)) begin
                laneBuf[gi*8 +: 8] <= rxData;
            end
        end
    end

    // Framing FSM with registered memory-write and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lenLo      <= '0;
            wordCount  <= '0;
            wordIdx    <= '0;
            byteIdx    <= '0;
            sum        <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_rst    <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (rxFerr && inFrame) begin
                state    <= ERR;
                load_err <= 1'b1;
            end else if (rxValid) begin
                case (state)
                    IDLE, ERR: begin
                        if (rxData == HDR_BYTE) begin
                            state     <= LEN_LO;
                            load_err  <= 1'b0;
                            sum       <= '0;
                            byteIdx   <= '0;
                            wordIdx   <= '0;
                            imem_addr <= '0;
                        end
                    end
                    LEN_LO: begin
                        lenLo <= rxData;
                        state <= LEN_HI;
                    end
                    LEN_HI: begin
                        wordCount <= rxLen;
                        if (rxLen > 16'(IMEM_DEPTH)) begin
                            state    <= ERR;
                            load_err <= 1'b1;
                        end else if (rxLen == 16'd0) begin
                            state <= CSUM;
                        end else begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        sum     <= sum + rxData;
                        byteIdx <= byteIdx + 1'b1;
                        if (byteIdx == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_wdata <= {rxData, laneBuf};
                            imem_addr  <= wordIdx[ADDR_W-1:0];
                            wordIdx    <= wordIdx + 16'd1;
                            if (wordIdx + 16'd1 == wordCount) begin
                                state <= CSUM;
                            end
                        end
                    end
                    CSUM: begin
                        if (rxData == sum) begin
                            state     <= DONE;
                            cpu_rst   <= 1'b0;
                            load_done <= 1'b1;
                        end else begin
                            state    <= ERR;
                            load_err <= 1'b1;
                        end
                    end
                    DONE: begin
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader with a frame-level expectation model.
module tb_uart_prog_loader;
    import loader_pkg::*;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          uart_rx = 1'b1;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_rst;
    logic          load_done;
    logic          load_err;

    uart_prog_loader #(
        .CLKS_PER_BIT(CPB),
        .IMEM_DEPTH  (DEPTH),
        .ADDR_W      (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_rst   (cpu_rst),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    int  vectors = 0;
    int  errors  = 0;
    wr_t expQ[$];
    int  obsWrites = 0;
    int  mWrites   = 0;
    bit  mDone     = 1'b0;
    bit  mErr      = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame-level model: find headers, decode length, list the complete
    // words that must be written, then decide done/error from the checksum.
    task automatic modelStream(input logic [7:0] b[$], input int ferrAt);
        int p, n, base, csumAt, full, avail;
        logic [7:0] s;
        p = 0;
        while (p < b.size() && !mDone) begin
            if (p == ferrAt || b[p] != HDR_BYTE) begin
                p++;
                continue;
            end
            mErr = 1'b0;
            p++;
            if (ferrAt == p || ferrAt == p + 1) begin
                mErr = 1'b1;
                p = ferrAt + 1;
                continue;
            end
            if (p + 1 >= b.size()) return;
            n = int'({b[p+1], b[p]});
            base = p + 2;
            if (n > DEPTH) begin
                mErr = 1'b1;
                p = base;
                continue;
            end
            csumAt = base + 4 * n;
            full = n;
            if (ferrAt >= base && ferrAt < csumAt) full = (ferrAt - base) / 4;
            avail = (b.size() - base) / 4;
            if (avail < full) full = avail;
            for (int w = 0; w < full; w++) begin
                expQ.push_back('{addr: AW'(w),
                                 data: {b[base+4*w+3], b[base+4*w+2], b[base+4*w+1], b[base+4*w]}});
                mWrites++;
            end
            if (ferrAt >= base && ferrAt <= csumAt) begin
                mErr = 1'b1;
                p = ferrAt + 1;
                continue;
            end
            if (csumAt >= b.size()) return;
            s = 8'd0;
            for (int i = base; i < csumAt; i++) s = s + b[i];
            if (s == b[csumAt]) mDone = 1'b1;
            else mErr = 1'b1;
            p = csumAt + 1;
        end
    endtask

    task automatic waitClks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b, input logic stopBit);
        uart_rx = 1'b0;
        waitClks(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            waitClks(CPB);
        end
        uart_rx = stopBit;
        waitClks(CPB);
        uart_rx = 1'b1;
        if (!stopBit) waitClks(CPB);
    endtask

    task automatic sendStream(input logic [7:0] b[$], input int ferrAt);
        for (int i = 0; i < b.size(); i++) sendByte(b[i], (i != ferrAt));
        waitClks(3 * CPB);
    endtask

    task automatic frame(input logic [7:0] b[$], input int ferrAt);
        modelStream(b, ferrAt);
        sendStream(b, ferrAt);
    endtask

    task automatic checkFlags(input string tag);
        check({tag, "_load_done"}, load_done, mDone);
        check({tag, "_load_err"},  load_err,  mErr);
        check({tag, "_cpu_rst"},   cpu_rst,   !mDone);
        check({tag, "_writes"},    obsWrites, mWrites);
        check({tag, "_pending"},   expQ.size(), 0);
    endtask

    task automatic checkResetValues(input string tag);
        check({tag, "_imem_we"},    imem_we,    0);
        check({tag, "_imem_addr"},  imem_addr,  0);
        check({tag, "_imem_wdata"}, imem_wdata, 0);
        check({tag, "_cpu_rst"},    cpu_rst,    1);
        check({tag, "_load_done"},  load_done,  0);
        check({tag, "_load_err"},   load_err,   0);
    endtask

    task automatic clearModel();
        mDone = 1'b0;
        mErr = 1'b0;
        mWrites = 0;
        obsWrites = 0;
        expQ.delete();
    endtask

    task automatic doReset();
        rst = 1'b1;
        waitClks(2);
        rst = 1'b0;
        clearModel();
        waitClks(2);
    endtask

    // Every cycle: status consistency, and each write against the model queue
    always @(negedge clk) begin
        if (!rst) check("cpu_rst_vs_load_done", cpu_rst, !load_done);
        if (imem_we) begin
            obsWrites++;
            $display("write addr=%0d data=0x%08h", imem_addr, imem_wdata);
            vectors++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %0d data 0x%08h, expected no write",
                         imem_addr, imem_wdata);
            end else begin
                check("write_addr", imem_addr, expQ[0].addr);
                check("write_data", imem_wdata, expQ[0].data);
                void'(expQ.pop_front());
            end
        end
    end

    initial begin
        logic [7:0] good[$];
        logic [7:0] bad[$];
        logic [7:0] tail[$];
        int rxSeen;

        // Payload sum 13+00+50+00+93+02+10+00 = 0x108 -> checksum byte 0x08
        good = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00,
                 8'h93, 8'h02, 8'h10, 8'h00, 8'h08};
        bad  = good;
        bad[11] = 8'hB8;

        // Reset state
        rst = 1'b1;
        waitClks(3);
        checkResetValues("reset");
        rst = 1'b0;
        waitClks(2);

        // Happy path, with the model's decoded words pinned by hand
        modelStream(good, -1);
        check("model_w0_addr", expQ[0].addr, 0);
        check("model_w0_data", expQ[0].data, 32'h00500013);
        check("model_w1_addr", expQ[1].addr, 1);
        check("model_w1_data", expQ[1].data, 32'h00100293);
        check("model_done", mDone, 1);
        sendStream(good, -1);
        checkFlags("happy");

        // Bad checksum, then the good frame; load_err must drop on the header
        doReset();
        frame(bad, -1);
        check("model_bad_err", mErr, 1);
        checkFlags("badcsum");
        modelStream(good, -1);
        sendByte(8'hA5, 1'b1);
        waitClks(3 * CPB);
        check("err_clear_on_hdr", load_err, 0);
        tail = good[1:$];
        sendStream(tail, -1);
        checkFlags("resend");

        // Word count larger than the memory
        doReset();
        frame('{8'hA5, 8'h09, 8'h00}, -1);
        check("model_oversize_err", mErr, 1);
        checkFlags("oversize");

        // Junk bytes and a one-cycle low glitch, then a good load
        doReset();
        frame('{8'h00, 8'hFF, 8'h3C}, -1);
        checkFlags("junk");
        rxSeen = 0;
        uart_rx = 1'b0;
        waitClks(1);
        uart_rx = 1'b1;
        for (int i = 0; i < 12 * CPB; i++) begin
            waitClks(1);
            if (dut.rxValid) rxSeen++;
        end
        check("glitch_rx_valid", rxSeen, 0);
        frame(good, -1);
        checkFlags("after_glitch");

        // Stop bit forced low on the third payload byte
        doReset();
        frame(good, 5);
        check("model_ferr_writes", mWrites, 0);
        checkFlags("ferr");

        // Empty image
        doReset();
        frame('{8'hA5, 8'h00, 8'h00, 8'h00}, -1);
        check("model_empty_done", mDone, 1);
        checkFlags("empty");

        // Reset after five payload bytes, then a full reload
        doReset();
        tail = good[0:7];
        frame(tail, -1);
        check("abort_writes", obsWrites, 1);
        rst = 1'b1;
        waitClks(1);
        checkResetValues("abort");
        rst = 1'b0;
        clearModel();
        waitClks(2);
        frame(good, -1);
        checkFlags("reload");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
